// File: rtl/sub_serial_if.sv
// Operand/result bundle shared by the bit-serial arithmetic units.
// The controller side drives en/a/b; the arithmetic unit drives the result
// and status flags back.
interface sub_serial_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             borrow_out;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output en, a, b,
    input  out, borrow_out, ovf, busy, done
  );

  modport slave (
    input  en, a, b,
    output out, borrow_out, ovf, busy, done
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
// Reports the final borrow (unsigned a < b) and signed overflow.
// busy/done are registered from the state, so each lags the state by one
// cycle: busy covers the WIDTH bit cycles and done pulses once, one cycle
// after the MSB has been processed.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  sub_serial_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow;
  logic [CNT_W-1:0] count;
  logic             sign_a;
  logic             sign_b;
  logic             diff;
  logic             borrow_next;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  always_comb begin
    diff        = a_reg[0] ^ b_reg[0] ^ borrow;
    borrow_next = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow);
  end

  // Control FSM and serial datapath; results hold in IDLE until the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      borrow         <= 1'b0;
      count          <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      bus.out        <= '0;
      bus.borrow_out <= 1'b0;
      bus.ovf        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.busy <= (state == SUB);
      bus.done <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.en) begin
            a_reg          <= bus.a;
            b_reg          <= bus.b;
            borrow         <= 1'b0;
            count          <= '0;
            bus.out        <= '0;
            bus.borrow_out <= 1'b0;
            bus.ovf        <= 1'b0;
            sign_a         <= bus.a[WIDTH-1];
            sign_b         <= bus.b[WIDTH-1];
            state          <= SUB;
          end
        end
        SUB: begin
          borrow  <= borrow_next;
          bus.out <= {diff, bus.out[WIDTH-1:1]};
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          count   <= count + CNT_W'(1);
          if (count == LAST) begin
            bus.borrow_out <= borrow_next;
            bus.ovf        <= (sign_a != sign_b) & (diff != sign_a);
            state          <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
